// File: rtl/timestamp_readout.sv
// timestamp_readout
// Snapshots the build-identification fields on request and streams them as a
// 10-byte packet (header, eight zero-extended fields, XOR checksum) over a
// valid/ready byte interface. Counts completed packets.
module timestamp_readout (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  compile_num,
    input  logic [6:0]  revision,
    input  logic [3:0]  subrevision,
    input  logic [6:0]  year,
    input  logic [3:0]  month,
    input  logic [4:0]  day,
    input  logic [4:0]  hour,
    input  logic [5:0]  minute,
    input  logic        req,
    output logic        busy,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        done,
    output logic [15:0] readout_count
);

    localparam logic [7:0] HEADER    = 8'hA5;
    localparam logic [3:0] LAST_BYTE = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_t;

    // Frozen copy of the identification fields, taken in LOAD.
    typedef struct packed {
        logic [7:0] compile_num;
        logic [6:0] revision;
        logic [3:0] subrevision;
        logic [6:0] year;
        logic [3:0] month;
        logic [4:0] day;
        logic [4:0] hour;
        logic [5:0] minute;
    } snap_t;

    state_t      state_q, state_d;
    snap_t       snap_q, snap_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  csum_q, csum_d;
    logic [15:0] count_q, count_d;
    logic        count_inc;
    logic [7:0]  byte_sel;
    logic        accept;

    // Select the packet byte addressed by the current index.
    always_comb begin
        byte_sel = 8'h00;
        case (idx_q)
            4'd0:    byte_sel = HEADER;
            4'd1:    byte_sel = snap_q.compile_num;
            4'd2:    byte_sel = {1'b0, snap_q.revision};
            4'd3:    byte_sel = {4'b0, snap_q.subrevision};
            4'd4:    byte_sel = {1'b0, snap_q.year};
            4'd5:    byte_sel = {4'b0, snap_q.month};
            4'd6:    byte_sel = {3'b0, snap_q.day};
            4'd7:    byte_sel = {3'b0, snap_q.hour};
            4'd8:    byte_sel = {2'b0, snap_q.minute};
            4'd9:    byte_sel = csum_q;
            default: byte_sel = 8'h00;
        endcase
    end

    // Next-state, snapshot, index, checksum and counter-enable logic.
    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        idx_d     = idx_q;
        csum_d    = csum_q;
        count_inc = 1'b0;
        accept    = (state_q == S_SEND) && out_ready;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                snap_d.compile_num = compile_num;
                snap_d.revision    = revision;
                snap_d.subrevision = subrevision;
                snap_d.year        = year;
                snap_d.month       = month;
                snap_d.day         = day;
                snap_d.hour        = hour;
                snap_d.minute      = minute;
                idx_d              = '0;
                csum_d             = '0;
                state_d            = S_SEND;
            end
            S_SEND: begin
                if (accept) begin
                    csum_d = csum_q ^ byte_sel;
                    if (idx_q == LAST_BYTE) begin
                        count_inc = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Counter increments on the edge that enters DONE, so the new value
    // appears together with the done pulse.
    assign count_d = count_q + 16'd1;

    // State, snapshot, index and checksum registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
        end
    end

    // Completed-packet counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (count_inc) begin
            count_q <= count_d;
        end
    end

    // Outputs decode directly from the registered state, so they cannot move
    // during a stall: index and snapshot only change on acceptance.
    always_comb begin
        busy          = (state_q != S_IDLE);
        out_valid     = (state_q == S_SEND);
        out_data      = (state_q == S_SEND) ? byte_sel : 8'h00;
        done          = (state_q == S_DONE);
        readout_count = count_q;
    end

endmodule

// File: tb/tb_timestamp_readout.sv
// Bench for timestamp_readout: directed sequence with randomized fields and
// ready patterns, checked against a packet model built from the field values.
module tb_timestamp_readout;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  compile_num;
    logic [6:0]  revision;
    logic [3:0]  subrevision;
    logic [6:0]  year;
    logic [3:0]  month;
    logic [4:0]  day;
    logic [4:0]  hour;
    logic [5:0]  minute;
    logic        req;
    logic        busy;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        done;
    logic [15:0] readout_count;

    int          vectors     = 0;
    int          miscompares = 0;
    int          model_count = 0;
    logic [7:0]  exp_pkt [10];
    logic [7:0]  last_csum;

    always #5 clk = ~clk;

    timestamp_readout dut (
        .clk           (clk),
        .reset         (reset),
        .compile_num   (compile_num),
        .revision      (revision),
        .subrevision   (subrevision),
        .year          (year),
        .month         (month),
        .day           (day),
        .hour          (hour),
        .minute        (minute),
        .req           (req),
        .busy          (busy),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .done          (done),
        .readout_count (readout_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packet as the host should see it, from the current field values.
    task automatic build_expected();
        logic [7:0] x;
        exp_pkt[0] = 8'hA5;
        exp_pkt[1] = compile_num;
        exp_pkt[2] = 8'(revision);
        exp_pkt[3] = 8'(subrevision);
        exp_pkt[4] = 8'(year);
        exp_pkt[5] = 8'(month);
        exp_pkt[6] = 8'(day);
        exp_pkt[7] = 8'(hour);
        exp_pkt[8] = 8'(minute);
        x = 8'h00;
        for (int i = 0; i < 9; i++) x = x ^ exp_pkt[i];
        exp_pkt[9] = x;
    endtask

    task automatic set_plan_fields();
        compile_num = 8'h12; revision = 7'd63; subrevision = 4'd7; year = 7'd8;
        month = 4'd12; day = 5'd9; hour = 5'd13; minute = 6'd46;
    endtask

    task automatic randomize_fields();
        compile_num = 8'($urandom); revision = 7'($urandom); subrevision = 4'($urandom);
        year = 7'($urandom); month = 4'($urandom); day = 5'($urandom);
        hour = 5'($urandom); minute = 6'($urandom);
    endtask

    // ready_mode: 0 always ready, 1 repeating 1,0,0,1, 2 random.
    task automatic run_packet(input int ready_mode, input bit mid_change, input bit timed);
        int         idx;
        bit         fin;
        bit         stalled;
        bit         changed;
        logic [7:0] prev;
        logic [3:0] pat;
        pat     = 4'b1001;
        build_expected();
        req       = 1'b1;
        out_ready = 1'b1;
        tick();
        req = 1'b0;
        check("load_busy", 32'(busy), 32'd1);
        check("load_valid", 32'(out_valid), 32'd0);
        idx = 0; fin = 0; stalled = 0; changed = 0; prev = 8'h00;
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            tick();
            req = 1'b0;
            if (done) begin
                check("done_index", 32'(idx), 32'd10);
                check("done_valid", 32'(out_valid), 32'd0);
                model_count++;
                check("count_at_done", 32'(readout_count), 32'(model_count & 16'hFFFF));
                if (timed) check("done_cycle", 32'(cyc), 32'd10);
                fin = 1;
            end else begin
                check("send_valid", 32'(out_valid), 32'd1);
                if (stalled) check("stall_hold", 32'(out_data), 32'(prev));
                if (idx < 10) check($sformatf("byte%0d", idx), 32'(out_data), 32'(exp_pkt[idx]));
                else check("extra_byte", 32'(idx), 32'd9);
                if (idx == 9) last_csum = out_data;
                prev = out_data;
                case (ready_mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = pat[cyc % 4];
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                stalled = !out_ready;
                if (mid_change && idx == 3 && !changed) begin
                    compile_num = '0; revision = '0; subrevision = '0; year = '0;
                    month = '0; day = '0; hour = '0; minute = '0;
                    req     = 1'b1;
                    changed = 1;
                end
                if (out_ready) idx++;
            end
        end
        if (!fin) check("packet_timeout", 32'd0, 32'd1);
        out_ready = 1'b1;
        tick();
        check("after_busy", 32'(busy), 32'd0);
        check("after_done", 32'(done), 32'd0);
        check("after_count", 32'(readout_count), 32'(model_count & 16'hFFFF));
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; out_ready = 1'b0;
        compile_num = '0; revision = '0; subrevision = '0; year = '0;
        month = '0; day = '0; hour = '0; minute = '0;
        last_csum = 8'h00;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(readout_count), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Reference packet, full rate, cycle-exact done.
        set_plan_fields();
        run_packet(0, 0, 1);
        check("plan_csum", 32'(last_csum), 32'hA1);
        check("plan_count", 32'(readout_count), 32'd1);

        // Same packet under the 1,0,0,1 ready pattern.
        set_plan_fields();
        run_packet(1, 0, 0);
        check("bp_csum", 32'(last_csum), 32'hA1);

        // Inputs cleared and extra req during SEND: snapshot must hold.
        set_plan_fields();
        run_packet(0, 1, 0);
        check("snap_csum", 32'(last_csum), 32'hA1);
        check("snap_count", 32'(readout_count), 32'd3);

        // Random fields with random backpressure.
        for (int p = 0; p < 6; p++) begin
            randomize_fields();
            run_packet(2, 0, 0);
        end

        // req held high: back-to-back packets with one IDLE cycle between.
        randomize_fields();
        build_expected();
        out_ready = 1'b1;
        req = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            int  ph;
            bit  act;
            tick();
            if (i == 38) req = 1'b0;
            ph  = i % 13;
            act = (i <= 38);
            check($sformatf("hold_done_%0d", i), 32'(done), 32'(act && ph == 12));
            check($sformatf("hold_busy_%0d", i), 32'(busy), 32'(act && ph != 0));
            check($sformatf("hold_valid_%0d", i), 32'(out_valid), 32'(act && ph >= 2 && ph <= 11));
            if (act && ph >= 2 && ph <= 11)
                check($sformatf("hold_byte_%0d", i), 32'(out_data), 32'(exp_pkt[ph - 2]));
        end
        model_count += 3;
        check("hold_count", 32'(readout_count), 32'(model_count & 16'hFFFF));

        // Reset while byte 5 is presented, with req asserted alongside.
        randomize_fields();
        build_expected();
        out_ready = 1'b1;
        req = 1'b1;
        tick();
        req = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("pre_rst_byte5", 32'(out_data), 32'(exp_pkt[5]));
        reset = 1'b1;
        req   = 1'b1;
        tick();
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_count", 32'(readout_count), 32'd0);
        reset = 1'b0;
        req   = 1'b0;
        model_count = 0;
        tick();
        check("postrst_busy", 32'(busy), 32'd0);
        check("postrst_done", 32'(done), 32'd0);
        randomize_fields();
        run_packet(0, 0, 1);
        check("postrst_count", 32'(readout_count), 32'd1);

        // Counter wrap from 16'hFFFF.
        force dut.count_q = 16'hFFFF;
        #2;
        release dut.count_q;
        check("preload_count", 32'(readout_count), 32'hFFFF);
        model_count = 16'hFFFF;
        randomize_fields();
        run_packet(0, 0, 1);
        check("wrap_count", 32'(readout_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
